uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  8N1 UART receiver, the receive-side counterpart of the UART clock/transmit path.
//  Runs in the slow main clock domain; bit timing comes from a one-cycle oversample
//  enable pulse derived from the baud clock. Deserialises the async i_rx line into
//  bytes and flags framing errors. Feeds command/logic blocks via a one-cycle valid strobe.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, LSB first
//  OVERSAMPLE  16  i_tick pulses per bit period; even, >=4
// PORTS
//  i_clk        in   1          main clock; all logic on rising edge
//  i_rst        in   1          synchronous, active-high reset
//  i_tick       in   1          oversample enable; high for 1 i_clk cycle per tick
//  i_rx         in   1          asynchronous serial line; idle high
//  o_data       out  DATA_BITS  last good byte; held until next good frame
//  o_valid      out  1          1-cycle pulse: o_data just updated
//  o_frame_err  out  1          1-cycle pulse: stop bit sampled low
//  o_busy       out  1          high in any state other than IDLE
// BEHAVIOUR
//  Reset: o_data=0, o_valid=0, o_frame_err=0, o_busy=0, state=IDLE, tick_cnt=0,
//   bit_cnt=0, sync flops and rx_prev =1. Reset mid-frame aborts frame, no pulse.
//  i_rx passes through 2-flop synchroniser (rx_s) every i_clk; rest of FSM advances
//   only on cycles with i_tick=1 (except o_valid/o_frame_err clear, see below).
//  rx_prev <= rx_s on every tick cycle.
//  IDLE:  on tick with rx_s=0 and rx_prev=1 (falling edge) -> START, tick_cnt=0.
//         Held-low line (break) never re-arms until line returns high.
//  START: tick_cnt++ per tick; at tick_cnt==OVERSAMPLE/2-1 sample rx_s:
//         1 -> IDLE (glitch, no pulse); 0 -> DATA, tick_cnt=0, bit_cnt=0.
//  DATA:  at tick_cnt==OVERSAMPLE-1 sample rx_s into shift reg (shift right,
//         new bit at MSB), tick_cnt=0, bit_cnt++; after DATA_BITS-th bit -> STOP.
//  STOP:  at tick_cnt==OVERSAMPLE-1 sample rx_s:
//         1 -> o_data<=shift reg, o_valid=1; 0 -> o_frame_err=1, o_data unchanged.
//         Either way -> IDLE same edge.
//  Pulses: o_valid/o_frame_err high exactly one i_clk cycle (the one after the
//   sampling tick edge), cleared next i_clk regardless of i_tick. Never both high.
//  Latency: o_valid rises 1 i_clk after stop-bit mid-sample, i.e. ~9.5 bit times
//   after start edge, +2 i_clk synchroniser delay.
//  Counters: tick_cnt width clog2(OVERSAMPLE), bit_cnt width clog2(DATA_BITS+1);
//   never wrap inside a state (reset on every transition).
//  Back-to-back: stop sampled mid-bit, so a start edge arriving half a bit later is
//   caught in IDLE; no minimum idle gap required.
//  o_busy = (state != IDLE), registered with the state.
// STRUCTURE
//  uart_defs.vh (shared with TX side): state encodings IDLE/START/DATA/STOP,
//   default DATA_BITS/OVERSAMPLE localparams.
//  Sub-module sync2: 2-flop synchroniser, reset value 1; reused for other async pins.
//  FSM, counters, shift register inline in uart_rx.
// TESTING (i_tick every 4 i_clk, OVERSAMPLE=16 unless noted)
//  1 Frame 0x55, 1 stop -> one o_valid, o_data=0x55, o_frame_err never high.
//  2 Frames 0xA3 then 0x00 then 0xFF back-to-back, zero idle -> three o_valid,
//    data 0xA3,0x00,0xFF in order.
//  3 i_rx low for 4 ticks then high -> returns IDLE, no o_valid, no o_frame_err.
//  4 Frame 0x7E with stop bit 0 after prior 0x12 -> o_frame_err pulse, o_data
//    stays 0x12; line held low 3 bit times -> no further pulses; then 0x3C -> valid.
//  5 i_rst=1 for 1 cycle after data bit 3 of 0x81, then frame 0x3C -> only 0x3C
//    reported, all outputs 0 during/after reset cycle.
//  6 i_tick tied high (tick every cycle) and ±3% baud skew on sender -> 0xC5 received.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: FSM state encoding and default frame geometry.
package uart_rx_pkg;
  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;
endpackage

// File: rtl/uart_rx_if.sv
// Receiver result bundle: last good byte, valid / frame-error strobes and busy flag.
interface uart_rx_if
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
);
  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 o_frame_err;
  logic                 o_busy;

  modport master (output o_data, o_valid, o_frame_err, o_busy);
  modport slave  (input  o_data, o_valid, o_frame_err, o_busy);
endinterface

// File: rtl/uart_rx_sync2.sv
// Two-flop synchroniser for an asynchronous pin; resets to 1 (idle-high line).
// Latency: 2 i_clk cycles.
// Backpressure: none, samples every cycle.
module uart_rx_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic meta;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta <= 1'b1;
      o_q  <= 1'b1;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: deserialises i_rx on oversample ticks, flags bad stop bits.
// Latency: o_valid 1 i_clk after the stop-bit mid-sample (+2 i_clk synchroniser).
// Backpressure: none; o_valid/o_frame_err are single-cycle strobes, consumer must take them.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_tick,
  input  logic      i_rx,
  uart_rx_if.master rx_if
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  rx_state_e            state, state_nxt;
  logic [TW-1:0]        tick_cnt, tick_cnt_nxt;
  logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shift_q, shift_nxt;
  logic [DATA_BITS-1:0] data_q, data_nxt;
  logic                 rx_s, rx_prev, rx_prev_nxt;
  logic                 valid_q, valid_nxt;
  logic                 ferr_q, ferr_nxt;
  logic                 busy_q;

  uart_rx_sync2 u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (rx_s)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      rx_prev  <= 1'b1;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shift_q  <= shift_nxt;
      data_q   <= data_nxt;
      rx_prev  <= rx_prev_nxt;
      valid_q  <= valid_nxt;
      ferr_q   <= ferr_nxt;
      busy_q   <= (state_nxt != ST_IDLE);
    end
  end

  // Strobes default low every cycle so they last exactly one i_clk, tick or not.
  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift_q;
    data_nxt     = data_q;
    rx_prev_nxt  = rx_prev;
    valid_nxt    = 1'b0;
    ferr_nxt     = 1'b0;
    if (i_tick) begin
      rx_prev_nxt = rx_s;
      case (state)
        ST_IDLE: begin
          // Edge-triggered start: a line held low (break) cannot re-arm.
          if (!rx_s && rx_prev) begin
            state_nxt    = ST_START;
            tick_cnt_nxt = '0;
          end
        end
        ST_START: begin
          if (tick_cnt == HALF_LAST) begin
            tick_cnt_nxt = '0;
            bit_cnt_nxt  = '0;
            state_nxt    = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            tick_cnt_nxt = tick_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (tick_cnt == BIT_LAST) begin
            tick_cnt_nxt = '0;
            shift_nxt    = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt_nxt = '0;
              state_nxt   = ST_STOP;
            end else begin
              bit_cnt_nxt = bit_cnt + 1'b1;
            end
          end else begin
            tick_cnt_nxt = tick_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          // Leave mid stop bit so a start edge half a bit later is still seen.
          if (tick_cnt == BIT_LAST) begin
            tick_cnt_nxt = '0;
            state_nxt    = ST_IDLE;
            if (rx_s) begin
              data_nxt  = shift_q;
              valid_nxt = 1'b1;
            end else begin
              ferr_nxt  = 1'b1;
            end
          end else begin
            tick_cnt_nxt = tick_cnt + 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign rx_if.o_data      = data_q;
  assign rx_if.o_valid     = valid_q;
  assign rx_if.o_frame_err = ferr_q;
  assign rx_if.o_busy      = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, hand-written corner sequences, random frames.
module tb_uart_rx;
  localparam int CLK_T = 100;
  localparam int BT4   = 16 * 4 * CLK_T;   // bit time with a tick every 4 clocks
  localparam int BT1   = 16 * CLK_T;       // bit time with a tick every clock

  typedef struct {
    logic       ferr;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic       exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  logic i_clk, i_rst, i_tick, i_rx;
  uart_rx_if #(.DATA_BITS(8)) rx_if ();

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_tick (i_tick),
    .i_rx   (i_rx),
    .rx_if  (rx_if)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   viol    = 0;
  int   tick_div = 4;
  int   tick_ph  = 0;
  ev_t  ev_q[$];
  ev_t  exp_q[$];
  logic [7:0] last_good = 8'h00;
  logic prev_v = 1'b0, prev_f = 1'b0;

  initial begin
    i_clk = 1'b0;
    forever #(CLK_T / 2) i_clk = ~i_clk;
  end

  initial begin
    i_tick = 1'b0;
    forever begin
      @(negedge i_clk);
      tick_ph = (tick_ph + 1 >= tick_div) ? 0 : tick_ph + 1;
      i_tick  = (tick_ph == 0);
    end
  end

  // Capture every strobe together with the o_data visible in that cycle.
  always @(negedge i_clk) begin
    ev_t e;
    if (rx_if.o_valid || rx_if.o_frame_err) begin
      e.ferr = rx_if.o_frame_err;
      e.data = rx_if.o_data;
      ev_q.push_back(e);
    end
    if (rx_if.o_valid && rx_if.o_frame_err) viol++;
    if ((rx_if.o_valid && prev_v) || (rx_if.o_frame_err && prev_f)) viol++;
    prev_v = rx_if.o_valid;
    prev_f = rx_if.o_frame_err;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic ev_t mk(input logic f, input logic [7:0] d);
    ev_t r;
    r.ferr = f;
    r.data = d;
    return r;
  endfunction

  // Reference model: a good stop bit delivers the byte, a bad one reports the held byte.
  task automatic model_frame(input logic [7:0] d, input logic stop);
    if (stop) begin
      exp_q.push_back(mk(1'b0, d));
      last_good = d;
    end else begin
      exp_q.push_back(mk(1'b1, last_good));
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int bt);
    i_rx = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      i_rx = d[i];
      #(bt);
    end
    i_rx = stop;
    #(bt);
  endtask

  task automatic idle(input int bits, input int bt);
    i_rx = 1'b1;
    #(bits * bt);
  endtask

  task automatic drain(input string name);
    ev_t e, a;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({name, "_present"}, 32'(ev_q.size() != 0), 32'd1);
      if (ev_q.size() != 0) begin
        a = ev_q.pop_front();
        check({name, "_kind"}, 32'(a.ferr), 32'(e.ferr));
        check({name, "_data"}, 32'(a.data), 32'(e.data));
      end
    end
    check({name, "_extra"}, 32'(ev_q.size()), 32'd0);
    ev_q.delete();
  endtask

  vec_t vt[7];

  initial begin
    i_rst = 1'b1;
    i_rx  = 1'b1;
    vt[0] = '{8'h55, 1'b1, 2, 1'b0, 8'h55};
    vt[1] = '{8'hA3, 1'b1, 0, 1'b0, 8'hA3};
    vt[2] = '{8'h00, 1'b1, 0, 1'b0, 8'h00};
    vt[3] = '{8'hFF, 1'b1, 2, 1'b0, 8'hFF};
    vt[4] = '{8'h12, 1'b1, 1, 1'b0, 8'h12};
    vt[5] = '{8'h7E, 1'b0, 2, 1'b1, 8'h12};
    vt[6] = '{8'h3C, 1'b1, 1, 1'b0, 8'h3C};

    repeat (3) @(negedge i_clk);
    check("rst_data",  32'(rx_if.o_data), 32'h0);
    check("rst_valid", 32'(rx_if.o_valid), 32'h0);
    check("rst_ferr",  32'(rx_if.o_frame_err), 32'h0);
    check("rst_busy",  32'(rx_if.o_busy), 32'h0);
    i_rst = 1'b0;
    idle(2, BT4);

    // Vector table: single frames, zero-gap run, bad stop bit.
    for (int i = 0; i < 7; i++) begin
      send_frame(vt[i].data, vt[i].stop, BT4);
      exp_q.push_back(mk(vt[i].exp_ferr, vt[i].exp_data));
      if (vt[i].gap > 0) begin
        idle(vt[i].gap, BT4);
        drain("vec");
        check("vec_hold", 32'(rx_if.o_data), 32'(vt[i].exp_data));
      end
    end
    last_good = 8'h3C;

    // Start glitch: low for 4 ticks only.
    i_rx = 1'b0;
    #(4 * 4 * CLK_T);
    idle(2, BT4);
    drain("glitch");
    check("glitch_busy", 32'(rx_if.o_busy), 32'h0);

    // Frame error followed by a 3-bit break, then recovery.
    send_frame(8'h12, 1'b1, BT4);
    model_frame(8'h12, 1'b1);
    send_frame(8'h7E, 1'b0, BT4);
    model_frame(8'h7E, 1'b0);
    #(3 * BT4);
    check("break_busy", 32'(rx_if.o_busy), 32'h0);
    drain("break");
    check("break_hold", 32'(rx_if.o_data), 32'h12);
    idle(1, BT4);
    send_frame(8'h3C, 1'b1, BT4);
    model_frame(8'h3C, 1'b1);
    idle(2, BT4);
    drain("recover");

    // Reset after data bit 3 of 0x81 aborts that frame silently.
    i_rx = 1'b0;
    #(BT4);
    for (int i = 0; i < 4; i++) begin
      i_rx = (i == 0) ? 1'b1 : 1'b0;
      #(BT4);
    end
    @(negedge i_clk);
    check("pre_rst_busy", 32'(rx_if.o_busy), 32'h1);
    i_rst = 1'b1;
    i_rx  = 1'b1;
    @(negedge i_clk);
    check("mid_rst_data",  32'(rx_if.o_data), 32'h0);
    check("mid_rst_valid", 32'(rx_if.o_valid), 32'h0);
    check("mid_rst_ferr",  32'(rx_if.o_frame_err), 32'h0);
    check("mid_rst_busy",  32'(rx_if.o_busy), 32'h0);
    i_rst = 1'b0;
    last_good = 8'h00;
    idle(2, BT4);
    drain("rst_abort");
    check("post_rst_data", 32'(rx_if.o_data), 32'h0);
    send_frame(8'h3C, 1'b1, BT4);
    model_frame(8'h3C, 1'b1);
    idle(2, BT4);
    drain("rst_next");

    // Random frames against the model.
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      logic       s;
      int         g;
      d = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 3) != 0);
      g = s ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      if (i == 19 && g == 0) g = 1;
      send_frame(d, s, BT4);
      model_frame(d, s);
      if (g > 0) begin
        idle(g, BT4);
        drain("rand");
        check("rand_hold", 32'(rx_if.o_data), 32'(last_good));
      end
    end

    // Tick every clock, sender baud skewed by +3% and -3%.
    tick_div = 1;
    idle(2, BT1);
    send_frame(8'hC5, 1'b1, int'(real'(BT1) * 1.03));
    model_frame(8'hC5, 1'b1);
    idle(2, BT1);
    drain("skew_slow");
    send_frame(8'hC5, 1'b1, int'(real'(BT1) * 0.97));
    model_frame(8'hC5, 1'b1);
    idle(2, BT1);
    drain("skew_fast");
    check("skew_hold", 32'(rx_if.o_data), 32'hC5);

    check("strobe_shape", 32'(viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
